// File: rtl/sa_ram_pkg.sv
// sa_ram_pkg
//   Definitions shared by the sa_ram family: default geometry, the BYPASS
//   mode encodings and an address-width helper.
//
//   Contents:
//     DEF_DEPTH / DEF_WIDTH / DEF_LANES  default geometry (160 x 65, 1 lane)
//     BYPASS_RBW / BYPASS_FWD            collision behaviour encodings
//     clog2_min1()                       ceil(log2(value)), never below 1
package sa_ram_pkg;

  localparam int DEF_DEPTH = 160;
  localparam int DEF_WIDTH = 65;
  localparam int DEF_LANES = 1;

  // Read-before-write: a colliding read returns the word as it was before
  // the write. Forwarding: the colliding read returns the merged new word.
  localparam int BYPASS_RBW = 0;
  localparam int BYPASS_FWD = 1;

  // Address width for a given depth. A one-word array still gets a 1-bit
  // address so that ports never collapse to zero width.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sa_ram_wmask_merge.sv
// sa_ram_wmask_merge
//   Per-lane merge of a new word into an old word. Lane i of the result is
//   new_word lane i when wmask[i] is set, otherwise old_word lane i.
//   Purely combinational; shared by the array write path and the
//   collision forwarding path so both agree bit for bit.
//
//   Ports:
//     old_word  [WIDTH-1:0]  word currently held
//     new_word  [WIDTH-1:0]  incoming write data
//     wmask     [LANES-1:0]  per-lane select, bit i covers [i*LW +: LW]
//     merged    [WIDTH-1:0]  resulting word
module sa_ram_wmask_merge
  import sa_ram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES
) (
  input  logic [WIDTH-1:0] old_word,
  input  logic [WIDTH-1:0] new_word,
  input  logic [LANES-1:0] wmask,
  output logic [WIDTH-1:0] merged
);

  localparam int LW = WIDTH / LANES;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign merged[i*LW +: LW] = wmask[i] ? new_word[i*LW +: LW]
                                         : old_word[i*LW +: LW];
  end

endmodule

// File: rtl/sa_ram_rwsp_param.sv
// sa_ram_rwsp_param
//   Single-clock, one-read/one-write RAM with lane write masks and a
//   two-stage read: stage 1 captures the read address, stage 2 reads the
//   array and loads the output register. Because the array is read in
//   stage 2, a write landing between the two stages is seen by the read.
//
//   Ports:
//     clk            rising-edge clock
//     rstn           asynchronous active-low reset (control and output regs)
//     ra   [AW-1:0]  read address, captured when re=1
//     re             read-address capture enable
//     ore            output-register load enable
//     dout [W-1:0]   registered read data (zero for an illegal address)
//     dout_vld       dout came from a legal captured address
//     wa   [AW-1:0]  write address
//     we             write enable
//     wmask[L-1:0]   per-lane write enable
//     di   [W-1:0]   write data
//     pwrbus_ram_pd  power bus, no functional effect
//     coll           one-cycle pulse after a same-address read/write edge
//     err_oob        one-cycle pulse after an out-of-range re or we
//
//   Enable semantics: re and ore are plain load enables with no
//   back-pressure. re=1 at an edge captures ra; ore=1 at an edge loads
//   dout/dout_vld from the address captured at an earlier edge. ore may
//   follow re by one or more cycles; with both high at the same edge, the
//   output uses the previously captured address and the new capture only
//   serves the next ore.
module sa_ram_rwsp_param
  import sa_ram_pkg::*;
#(
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int LANES  = DEF_LANES,
  parameter  int BYPASS = BYPASS_RBW,
  localparam int AW     = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [AW-1:0]     ra,
  input  logic              re,
  input  logic              ore,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_vld,
  input  logic [AW-1:0]     wa,
  input  logic              we,
  input  logic [LANES-1:0]  wmask,
  input  logic [WIDTH-1:0]  di,
  input  logic [31:0]       pwrbus_ram_pd,
  output logic              coll,
  output logic              err_oob
);

  // Reject geometries the lane slicing and addressing cannot represent.
  if (LANES < 1 || (WIDTH % LANES) != 0 || DEPTH < 2) begin : g_param_check
    $error("sa_ram_rwsp_param: WIDTH must be a multiple of LANES and DEPTH >= 2");
  end

  // The power bus only exists for integration; fold it into a sink.
  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  // Storage. Deliberately not reset: contents are undefined until written.
  logic [WIDTH-1:0] mem [DEPTH];

  // Stage-1 state.
  logic [AW-1:0] ra_d;
  logic          a_vld;

  // Address range qualification. AW may cover more than DEPTH words when
  // DEPTH is not a power of two, so every access is compared explicitly.
  logic ra_ok;
  logic wa_ok;
  assign ra_ok = (32'(ra) < 32'(DEPTH));
  assign wa_ok = (32'(wa) < 32'(DEPTH));

  // ---------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------
  logic             wr_en;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_word;

  assign wr_en  = we & wa_ok;
  assign wr_old = mem[wa];

  sa_ram_wmask_merge #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_wr_merge (
    .old_word (wr_old),
    .new_word (di),
    .wmask    (wmask),
    .merged   (wr_word)
  );

  // An all-zero mask rewrites the old word unchanged, which keeps the
  // write enable independent of the mask.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wa] <= wr_word;
    end
  end

  // ---------------------------------------------------------------------
  // Read path (stage 2 array read)
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_sel;
  logic [WIDTH-1:0] dout_nxt;
  logic             coll_now;
  logic             err_now;

  // rd_word is the pre-write value at a colliding edge because the array
  // update is non-blocking.
  assign rd_word = mem[ra_d];

  // A collision needs a legal captured address and a legal write to the
  // same word at an edge that also loads the output register.
  assign coll_now = ore & we & a_vld & wa_ok & (wa == ra_d);

  if (BYPASS == BYPASS_FWD) begin : g_fwd
    logic [WIDTH-1:0] byp_word;

    sa_ram_wmask_merge #(
      .WIDTH (WIDTH),
      .LANES (LANES)
    ) u_byp_merge (
      .old_word (rd_word),
      .new_word (di),
      .wmask    (wmask),
      .merged   (byp_word)
    );

    assign rd_sel = coll_now ? byp_word : rd_word;
  end else begin : g_rbw
    assign rd_sel = rd_word;
  end

  // An illegal captured address yields zero rather than whatever the
  // out-of-range index happens to read.
  assign dout_nxt = a_vld ? rd_sel : '0;

  assign err_now = (re & ~ra_ok) | (we & ~wa_ok);

  // ---------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ra_d     <= '0;
      a_vld    <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      coll     <= 1'b0;
      err_oob  <= 1'b0;
    end else begin
      if (re) begin
        ra_d  <= ra;
        a_vld <= ra_ok;
      end
      if (ore) begin
        dout     <= dout_nxt;
        dout_vld <= a_vld;
      end
      coll    <= coll_now;
      err_oob <= err_now;
    end
  end

endmodule

// File: tb/tb_sa_ram_rwsp_param.sv
// tb_sa_ram_rwsp_param
//   Three instances share one stimulus stream: defaults (1 lane,
//   read-before-write), 5 lanes read-before-write, 5 lanes forwarding.
//   Expected words come from a table of constants, hand-written sequences
//   and a reference memory per lane geometry feeding expected queues.
module tb_sa_ram_rwsp_param;

  localparam int DEPTH = 160;
  localparam int WIDTH = 65;
  localparam int AW    = 8;
  localparam int LW5   = 13;

  localparam logic [WIDTH-1:0] DPAT  = {13'h1AAA, 13'h0555, 13'h1234, 13'h0F0F, 13'h1FFF};
  localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] L02Z  = {13'h1FFF, 13'h1FFF, 13'h0000, 13'h1FFF, 13'h0000};
  localparam logic [WIDTH-1:0] BEEF  = 65'h1_DEAD_BEEF_0123_4567;
  localparam logic [WIDTH-1:0] LATE  = 65'h0_1234_5678_9ABC_DEF0;
  localparam logic [WIDTH-1:0] RSTW  = 65'h1_0F0F_F0F0_5A5A_A5A5;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic [AW-1:0]    ra = '0;
  logic [AW-1:0]    wa = '0;
  logic             re = 1'b0;
  logic             ore = 1'b0;
  logic             we = 1'b0;
  logic [WIDTH-1:0] di = '0;
  logic             wmask1 = 1'b0;
  logic [4:0]       wmask5 = '0;
  logic [31:0]      pwr = 32'h0;

  logic [WIDTH-1:0] dout_def, dout_rbw, dout_fwd;
  logic             vld_def, vld_rbw, vld_fwd;
  logic             coll_def, coll_rbw, coll_fwd;
  logic             err_def, err_rbw, err_fwd;

  sa_ram_rwsp_param u_def (
    .clk (clk), .rstn (rstn), .ra (ra), .re (re), .ore (ore),
    .dout (dout_def), .dout_vld (vld_def), .wa (wa), .we (we),
    .wmask (wmask1), .di (di), .pwrbus_ram_pd (pwr),
    .coll (coll_def), .err_oob (err_def)
  );

  sa_ram_rwsp_param #(.LANES(5), .BYPASS(0)) u_rbw (
    .clk (clk), .rstn (rstn), .ra (ra), .re (re), .ore (ore),
    .dout (dout_rbw), .dout_vld (vld_rbw), .wa (wa), .we (we),
    .wmask (wmask5), .di (di), .pwrbus_ram_pd (pwr),
    .coll (coll_rbw), .err_oob (err_rbw)
  );

  sa_ram_rwsp_param #(.LANES(5), .BYPASS(1)) u_fwd (
    .clk (clk), .rstn (rstn), .ra (ra), .re (re), .ore (ore),
    .dout (dout_fwd), .dout_vld (vld_fwd), .wa (wa), .we (we),
    .wmask (wmask5), .di (di), .pwrbus_ram_pd (pwr),
    .coll (coll_fwd), .err_oob (err_fwd)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] m_def [DEPTH];
  logic [WIDTH-1:0] m_l5  [DEPTH];
  logic [WIDTH-1:0] exp_q  [$];
  logic [WIDTH-1:0] exp5_q [$];

  typedef struct {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] di;
    logic [4:0]       mask;
    logic [WIDTH-1:0] exp5;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [WIDTH-1:0] merge5(input logic [WIDTH-1:0] old_w,
                                              input logic [WIDTH-1:0] new_w,
                                              input logic [4:0] m);
    logic [WIDTH-1:0] r;
    r = old_w;
    for (int i = 0; i < 5; i++) begin
      if (m[i]) r[i*LW5 +: LW5] = new_w[i*LW5 +: LW5];
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    re  = 1'b0;
    ore = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                    input logic m1, input logic [4:0] m5);
    we = 1'b1; wa = a; di = d; wmask1 = m1; wmask5 = m5;
    tick();
    we = 1'b0;
    if (int'(a) < DEPTH) begin
      if (m1) m_def[a] = d;
      m_l5[a] = merge5(m_l5[a], d, m5);
    end
  endtask

  task automatic rd(input logic [AW-1:0] a);
    re = 1'b1; ra = a;
    tick();
    re = 1'b0; ore = 1'b1;
    tick();
    ore = 1'b0;
  endtask

  task automatic check_zero_all(input string tag);
    check({tag, "_dout_def"}, dout_def, '0);
    check({tag, "_dout_rbw"}, dout_rbw, '0);
    check({tag, "_dout_fwd"}, dout_fwd, '0);
    check({tag, "_vld_def"}, vld_def, 1'b0);
    check({tag, "_vld_fwd"}, vld_fwd, 1'b0);
    check({tag, "_coll_def"}, coll_def, 1'b0);
    check({tag, "_coll_fwd"}, coll_fwd, 1'b0);
    check({tag, "_err_def"}, err_def, 1'b0);
    check({tag, "_err_rbw"}, err_rbw, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  logic [WIDTH-1:0] e, e5;
  logic [95:0]      rnd;

  initial begin
    vecs[0] = '{addr: 8'd3,   di: DPAT, mask: 5'b00001,
                exp5: {13'h0000, 13'h0000, 13'h0000, 13'h0000, 13'h1FFF}};
    vecs[1] = '{addr: 8'd10,  di: DPAT, mask: 5'b10000,
                exp5: {13'h1AAA, 13'h0000, 13'h0000, 13'h0000, 13'h0000}};
    vecs[2] = '{addr: 8'd159, di: DPAT, mask: 5'b01010,
                exp5: {13'h0000, 13'h0555, 13'h0000, 13'h0F0F, 13'h0000}};
    vecs[3] = '{addr: 8'd0,   di: DPAT, mask: 5'b00000, exp5: '0};
    vecs[4] = '{addr: 8'd64,  di: DPAT, mask: 5'b11111, exp5: DPAT};
    vecs[5] = '{addr: 8'd100, di: DPAT, mask: 5'b10101,
                exp5: {13'h1AAA, 13'h0000, 13'h1234, 13'h0000, 13'h1FFF}};

    pwr = $urandom;

    // Reset state
    tick();
    tick();
    check_zero_all("reset");
    rstn = 1'b1;

    // Fill every word, then random masked rewrites
    for (int a = 0; a < DEPTH; a++) begin
      rnd = {$urandom, $urandom, $urandom};
      wr(AW'(a), rnd[WIDTH-1:0], 1'b1, 5'h1f);
    end
    for (int a = 0; a < DEPTH; a += 3) begin
      rnd = {$urandom, $urandom, $urandom};
      wr(AW'(a), rnd[WIDTH-1:0], 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    // Basic write/read, 2-cycle latency
    wr(8'd5, BEEF, 1'b1, 5'h1f);
    rd(8'd5);
    check("basic_dout_def", dout_def, BEEF);
    check("basic_vld_def", vld_def, 1'b1);
    check("basic_dout_rbw", dout_rbw, BEEF);

    // Table-driven lane masks
    for (int v = 0; v < 6; v++) begin
      wr(vecs[v].addr, '0, 1'b1, 5'h1f);
      wr(vecs[v].addr, vecs[v].di, 1'b1, vecs[v].mask);
      rd(vecs[v].addr);
      check($sformatf("vec%0d_def", v), dout_def, vecs[v].di);
      check($sformatf("vec%0d_rbw", v), dout_rbw, vecs[v].exp5);
      check($sformatf("vec%0d_fwd", v), dout_fwd, vecs[v].exp5);
      check($sformatf("vec%0d_vld", v), vld_rbw, 1'b1);
    end

    // Collision, masked lanes 0 and 2
    wr(8'd7, ONES, 1'b1, 5'h1f);
    re = 1'b1; ra = 8'd7;
    tick();
    re = 1'b0;
    ore = 1'b1; we = 1'b1; wa = 8'd7; di = '0; wmask1 = 1'b1; wmask5 = 5'b00101;
    tick();
    idle();
    m_def[7] = '0;
    m_l5[7]  = L02Z;
    check("coll_dout_def", dout_def, ONES);
    check("coll_dout_rbw", dout_rbw, ONES);
    check("coll_dout_fwd", dout_fwd, L02Z);
    check("coll_pulse_def", coll_def, 1'b1);
    check("coll_pulse_rbw", coll_rbw, 1'b1);
    check("coll_pulse_fwd", coll_fwd, 1'b1);
    tick();
    check("coll_end_rbw", coll_rbw, 1'b0);
    check("coll_end_fwd", coll_fwd, 1'b0);
    rd(8'd7);
    check("after_coll_def", dout_def, '0);
    check("after_coll_rbw", dout_rbw, L02Z);
    check("after_coll_fwd", dout_fwd, L02Z);

    // Collision with all-zero mask: flagged, no data change
    re = 1'b1; ra = 8'd7;
    tick();
    re = 1'b0;
    ore = 1'b1; we = 1'b1; wa = 8'd7; di = ONES; wmask1 = 1'b0; wmask5 = 5'b00000;
    tick();
    idle();
    check("zmask_coll_def", coll_def, 1'b1);
    check("zmask_coll_fwd", coll_fwd, 1'b1);
    check("zmask_dout_fwd", dout_fwd, L02Z);
    check("zmask_dout_def", dout_def, '0);
    rd(8'd7);
    check("zmask_after_rbw", dout_rbw, L02Z);

    // Simultaneous re and ore use the old capture
    re = 1'b1; ra = 8'd5;
    tick();
    ra = 8'd7; ore = 1'b1;
    tick();
    check("reore_old_def", dout_def, m_def[5]);
    check("reore_old_fwd", dout_fwd, m_l5[5]);
    re = 1'b0;
    tick();
    idle();
    check("reore_new_def", dout_def, m_def[7]);
    check("reore_new_rbw", dout_rbw, m_l5[7]);

    // Write between capture and ore is seen by the read
    re = 1'b1; ra = 8'd9;
    tick();
    re = 1'b0;
    wr(8'd9, LATE, 1'b1, 5'h1f);
    ore = 1'b1;
    tick();
    ore = 1'b0;
    check("late_wr_def", dout_def, LATE);
    check("late_wr_fwd", dout_fwd, LATE);

    // Out-of-range read and write
    re = 1'b1; ra = 8'd200;
    tick();
    re = 1'b0;
    check("oob_rd_err_def", err_def, 1'b1);
    check("oob_rd_err_fwd", err_fwd, 1'b1);
    ore = 1'b1;
    tick();
    ore = 1'b0;
    check("oob_rd_err_end", err_def, 1'b0);
    check("oob_rd_dout", dout_def, '0);
    check("oob_rd_vld", vld_def, 1'b0);
    check("oob_rd_vld_rbw", vld_rbw, 1'b0);
    wr(8'd170, ONES, 1'b1, 5'h1f);
    check("oob_wr_err_def", err_def, 1'b1);
    check("oob_wr_err_rbw", err_rbw, 1'b1);
    tick();
    check("oob_wr_err_end", err_def, 1'b0);

    // Back-to-back sweep, re and ore every cycle
    for (int k = 0; k <= DEPTH; k++) begin
      re  = (k < DEPTH);
      ra  = AW'(k);
      ore = (k >= 1);
      if (k < DEPTH) begin
        exp_q.push_back(m_def[k]);
        exp5_q.push_back(m_l5[k]);
      end
      tick();
      if (k >= 1) begin
        e  = exp_q.pop_front();
        e5 = exp5_q.pop_front();
        check($sformatf("sweep%0d_def", k - 1), dout_def, e);
        check($sformatf("sweep%0d_rbw", k - 1), dout_rbw, e5);
        check($sformatf("sweep%0d_fwd", k - 1), dout_fwd, e5);
        check($sformatf("sweep%0d_vld", k - 1), vld_def, 1'b1);
      end
    end
    idle();

    // Reset mid-read, error pulse pending
    re = 1'b1; ra = 8'd5; we = 1'b1; wa = 8'd170; di = ONES;
    tick();
    idle();
    check("rst1_pre_err", err_def, 1'b1);
    check("rst1_pre_vld", vld_def, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check_zero_all("rst1");
    rstn = 1'b1;
    ore = 1'b1;
    tick();
    ore = 1'b0;
    check("rst1_post_vld", vld_def, 1'b0);
    check("rst1_post_dout", dout_fwd, '0);

    // Reset mid-read, collision pulse pending
    re = 1'b1; ra = 8'd5;
    tick();
    ore = 1'b1; we = 1'b1; wa = 8'd5; di = RSTW; wmask1 = 1'b1; wmask5 = 5'h1f;
    tick();
    idle();
    m_def[5] = RSTW;
    m_l5[5]  = RSTW;
    check("rst2_pre_coll", coll_def, 1'b1);
    check("rst2_pre_vld", vld_rbw, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check_zero_all("rst2");
    rstn = 1'b1;
    ore = 1'b1;
    tick();
    ore = 1'b0;
    check("rst2_post_vld", vld_rbw, 1'b0);
    rd(8'd5);
    check("rst2_mem_kept_def", dout_def, m_def[5]);
    check("rst2_mem_kept_fwd", dout_fwd, m_l5[5]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sa_ram_rwsp_param.md
SA_RAM_RWSP_PARAM -- requirements
Module: sa_ram_rwsp_param

Interface
REQ-001 The block SHALL take parameter DEPTH, default 160: number of words.
REQ-002 The block SHALL take parameter WIDTH, default 65: word width in bits.
REQ-003 The block SHALL take parameter LANES, default 1: write-mask lanes; WIDTH mod LANES == 0, lane width LW = WIDTH/LANES.
REQ-004 The block SHALL take parameter BYPASS, default 0: 1 = write-to-read forwarding on collision, 0 = read-before-write.
REQ-005 The block SHALL derive localparam AW = clog2(DEPTH), minimum 1.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port ra, input, AW bits: read address.
REQ-009 The block SHALL have port re, input, 1 bit: read-address capture enable.
REQ-010 The block SHALL have port ore, input, 1 bit: output-register load enable.
REQ-011 The block SHALL have port dout, output, WIDTH bits: registered read data.
REQ-012 The block SHALL have port dout_vld, output, 1 bit: dout holds data from a legal captured address.
REQ-013 The block SHALL have port wa, input, AW bits: write address.
REQ-014 The block SHALL have port we, input, 1 bit: write enable.
REQ-015 The block SHALL have port wmask, input, LANES bits: per-lane write enable; bit i covers di[i*LW +: LW].
REQ-016 The block SHALL have port di, input, WIDTH bits: write data.
REQ-017 The block SHALL have port pwrbus_ram_pd, input, 32 bits: power bus; accepted and functionally ignored.
REQ-018 The block SHALL have port coll, output, 1 bit: registered one-cycle pulse on same-address read/write collision.
REQ-019 The block SHALL have port err_oob, output, 1 bit: registered one-cycle pulse on out-of-range access.

Function
REQ-020 Write: at a rising edge with we=1 and wa<DEPTH, each lane i with wmask[i]=1 SHALL take di lane i; lanes with wmask[i]=0 SHALL keep their value.
REQ-021 Read stage 1: at a rising edge with re=1, ra_d SHALL load ra and a_vld SHALL load (ra<DEPTH); with re=0 both SHALL hold.
REQ-022 Read stage 2: at a rising edge with ore=1, dout SHALL load M[ra_d] if a_vld=1, else all-zero, and dout_vld SHALL load a_vld; with ore=0 both SHALL hold.
REQ-023 Latency: re at edge N followed by ore at edge N+1 SHALL present data on dout after edge N+1, giving 2-cycle read latency; ore MAY lag re by any number of cycles.
REQ-024 Collision is defined as ore=1, we=1, a_vld=1, wa==ra_d and wa<DEPTH at the same edge.
REQ-025 On a collision with BYPASS=0, dout SHALL load the pre-write word.
REQ-026 On a collision with BYPASS=1, dout SHALL load the pre-write word with the masked lanes replaced by di.
REQ-027 In either BYPASS mode, a collision SHALL set coll=1 for exactly the following cycle.
REQ-028 A write to ra_d at an edge before ore SHALL be visible at the later ore, because the array is read at stage 2.
REQ-029 err_oob SHALL pulse for one cycle after any edge with (re=1 and ra>=DEPTH) or (we=1 and wa>=DEPTH); an out-of-range write SHALL not modify the array.
REQ-030 A simultaneous re and ore SHALL use the old ra_d/a_vld for dout, the new capture affecting only the next ore.
REQ-031 A write with wmask all-zero SHALL change no array bits but SHALL still count for collision detection.

Reset
REQ-032 While rstn=0, ra_d, a_vld, dout, dout_vld, coll and err_oob SHALL be 0 immediately, independent of clk.
REQ-033 Array contents SHALL not be reset and are undefined until written; a reset asserted mid-read SHALL drop that read (dout_vld=0 after release).

Structure
REQ-034 Shared package sa_ram_pkg SHALL hold the clog2 function, the default DEPTH/WIDTH/LANES constants and the BYPASS mode encodings.
REQ-035 Lane merge (old word, di, wmask -> merged word) SHALL be one sub-module sa_ram_wmask_merge, used by the write path and the bypass path.
REQ-036 An elaboration-time check SHALL reject WIDTH mod LANES != 0 or DEPTH < 2.

Verification
REQ-037 With defaults, write wa=5 di=0x1_DEAD_BEEF_0123_4567, then re ra=5 and ore on the next edge -> dout=0x1_DEAD_BEEF_0123_4567 and dout_vld=1 two edges after re.
REQ-038 With LANES=5 and BYPASS=0: preload addr 7 = all-ones, capture ra=7, then ore together with we wa=7 di=0 wmask=5'b00101 -> dout=all-ones and coll pulses; the next read returns lanes 0 and 2 zero.
REQ-039 Repeat REQ-038 with BYPASS=1 -> dout lanes 0 and 2 = 0 and the other lanes all ones on the collision read; coll pulses.
REQ-040 re ra=200 (DEPTH=160) then ore -> err_oob pulses one cycle, dout=0, dout_vld=0; we wa=170 -> err_oob pulses and addresses 0-159 are unchanged.
REQ-041 re captured, rstn asserted between edges -> dout, dout_vld, coll and err_oob go 0 asynchronously; ore after release gives dout_vld=0.
REQ-042 Back-to-back re every cycle over addresses 0..159 with ore every cycle -> each dout equals the word at the address captured two edges earlier, with no bubbles.
